// File: rtl/ft60x_dev_model_if.sv
// ft60x_dev_model_if: FT60x FIFO-bus strobes/flags plus host-side streams.
// slave  = device model side, master = FPGA/host environment side.
// The 32-bit data and byte-enable lines stay plain inout ports on the model.
interface ft60x_dev_model_if;
    logic        RXF_N_o;
    logic        TXE_N_o;
    logic        OE_N_i;
    logic        RD_N_i;
    logic        WR_N_i;
    logic [31:0] H_TX_DATA_i;
    logic [3:0]  H_TX_BE_i;
    logic        H_TX_VALID_i;
    logic        H_TX_READY_o;
    logic [31:0] H_RX_DATA_o;
    logic [3:0]  H_RX_BE_o;
    logic        H_RX_VALID_o;
    logic        H_RX_READY_i;

    modport slave (
        output RXF_N_o, TXE_N_o, H_TX_READY_o, H_RX_DATA_o, H_RX_BE_o, H_RX_VALID_o,
        input  OE_N_i, RD_N_i, WR_N_i, H_TX_DATA_i, H_TX_BE_i, H_TX_VALID_i, H_RX_READY_i
    );

    modport master (
        input  RXF_N_o, TXE_N_o, H_TX_READY_o, H_RX_DATA_o, H_RX_BE_o, H_RX_VALID_o,
        output OE_N_i, RD_N_i, WR_N_i, H_TX_DATA_i, H_TX_BE_i, H_TX_VALID_i, H_RX_READY_i
    );
endinterface

// File: rtl/ft60x_dev_model.sv
// ft60x_dev_model: FT60x-style synchronous FIFO-bus device model.
// Down FIFO: host -> FPGA (read by OE_N/RD_N); up FIFO: FPGA -> host (WR_N).
// RXF_N/TXE_N are registered from the post-edge occupancy, so the last pop
// raises RXF_N at the same edge and the master never sees an extra word.
// Optional protocol checker driving ERR_o: define FT60X_DEV_PROTOCHK_EN.
module ft60x_dev_model #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic             CLK_i,
    input  logic             Rst_i,
    inout  wire  [31:0]      DATA_io,
    inout  wire  [3:0]       BE_io,
    output logic             ERR_o,
    ft60x_dev_model_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    // down FIFO (device -> FPGA)
    logic [35:0] dn_mem [DEPTH];
    ptr_t        dn_wr_ptr;
    ptr_t        dn_rd_ptr;
    cnt_t        dn_cnt;
    cnt_t        dn_cnt_nxt;
    logic        dn_push;
    logic        dn_pop;
    logic        rxf_n_q;
    logic        tx_ready_q;
    logic [35:0] dn_head;

    // up FIFO (FPGA -> device)
    logic [35:0] up_mem [DEPTH];
    ptr_t        up_wr_ptr;
    ptr_t        up_rd_ptr;
    cnt_t        up_cnt;
    cnt_t        up_cnt_nxt;
    logic        up_push;
    logic        up_pop;
    logic        txe_n_q;
    logic        rx_valid_q;
    logic [35:0] up_head;

    logic        bus_drive;

    assign dn_push    = bus.H_TX_VALID_i & tx_ready_q;
    assign dn_pop     = ~bus.OE_N_i & ~bus.RD_N_i & ~rxf_n_q;
    assign dn_cnt_nxt = dn_cnt + cnt_t'(dn_push) - cnt_t'(dn_pop);

    assign up_push    = ~bus.WR_N_i & ~txe_n_q;
    assign up_pop     = rx_valid_q & bus.H_RX_READY_i;
    assign up_cnt_nxt = up_cnt + cnt_t'(up_push) - cnt_t'(up_pop);

    // Down FIFO storage write from the host side.
    always_ff @(posedge CLK_i) begin
        if (!Rst_i && dn_push) begin
            dn_mem[dn_wr_ptr] <= {bus.H_TX_BE_i, bus.H_TX_DATA_i};
        end
    end

    // Down FIFO pointers, occupancy and registered RXF_N / host-ready flags.
    always_ff @(posedge CLK_i) begin
        if (Rst_i) begin
            dn_wr_ptr  <= '0;
            dn_rd_ptr  <= '0;
            dn_cnt     <= '0;
            rxf_n_q    <= 1'b1;
            tx_ready_q <= 1'b0;
        end else begin
            if (dn_push) begin
                dn_wr_ptr <= dn_wr_ptr + ptr_t'(1);
            end
            if (dn_pop) begin
                dn_rd_ptr <= dn_rd_ptr + ptr_t'(1);
            end
            dn_cnt     <= dn_cnt_nxt;
            rxf_n_q    <= (dn_cnt_nxt == '0);
            tx_ready_q <= (dn_cnt_nxt < FULL_CNT);
        end
    end

    // Up FIFO storage write, capturing the FIFO bus.
    always_ff @(posedge CLK_i) begin
        if (!Rst_i && up_push) begin
            up_mem[up_wr_ptr] <= {BE_io, DATA_io};
        end
    end

    // Up FIFO pointers, occupancy and registered TXE_N / host-valid flags.
    always_ff @(posedge CLK_i) begin
        if (Rst_i) begin
            up_wr_ptr  <= '0;
            up_rd_ptr  <= '0;
            up_cnt     <= '0;
            txe_n_q    <= 1'b1;
            rx_valid_q <= 1'b0;
        end else begin
            if (up_push) begin
                up_wr_ptr <= up_wr_ptr + ptr_t'(1);
            end
            if (up_pop) begin
                up_rd_ptr <= up_rd_ptr + ptr_t'(1);
            end
            up_cnt     <= up_cnt_nxt;
            txe_n_q    <= (up_cnt_nxt == FULL_CNT);
            rx_valid_q <= (up_cnt_nxt != '0);
        end
    end

    assign dn_head = dn_mem[dn_rd_ptr];
    assign up_head = up_mem[up_rd_ptr];

    assign bus.RXF_N_o      = rxf_n_q;
    assign bus.TXE_N_o      = txe_n_q;
    assign bus.H_TX_READY_o = tx_ready_q;
    assign bus.H_RX_VALID_o = rx_valid_q;
    assign bus.H_RX_DATA_o  = up_head[31:0];
    assign bus.H_RX_BE_o    = up_head[35:32];

    // Bus is released during reset and whenever the master is writing.
    assign bus_drive = ~Rst_i & ~bus.OE_N_i & bus.WR_N_i;
    assign DATA_io   = bus_drive ? dn_head[31:0]  : 'z;
    assign BE_io     = bus_drive ? dn_head[35:32] : 'z;

`ifdef FT60X_DEV_PROTOCHK_EN
    logic err_q;
    logic proto_viol;

    assign proto_viol = (~bus.OE_N_i & ~bus.WR_N_i)
                      | (~bus.RD_N_i &  bus.OE_N_i)
                      | (~bus.RD_N_i &  rxf_n_q)
                      | (~bus.WR_N_i &  txe_n_q);

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge CLK_i) begin
        if (Rst_i) begin
            err_q <= 1'b0;
        end else if (proto_viol) begin
            err_q <= 1'b1;
        end
    end

    assign ERR_o = err_q;
`else
    assign ERR_o = 1'b0;
`endif
endmodule

// File: tb/tb_ft60x_dev_model.sv
// tb_ft60x_dev_model: table-driven vectors plus directed multi-cycle sequences.
module tb_ft60x_dev_model;
    logic        clk;
    logic        rst_i;
    logic        err_o;
    logic        tb_wr_en;
    logic [31:0] tb_wd;
    wire  [31:0] data_bus;
    wire  [3:0]  be_bus;

    int n_cmp = 0;
    int n_err = 0;

    ft60x_dev_model_if bus_if ();

    ft60x_dev_model #(.DEPTH_LOG2(4)) dut (
        .CLK_i   (clk),
        .Rst_i   (rst_i),
        .DATA_io (data_bus),
        .BE_io   (be_bus),
        .ERR_o   (err_o),
        .bus     (bus_if)
    );

    assign tb_wr_en = ~bus_if.WR_N_i;
    assign data_bus = tb_wr_en ? tb_wd : 'z;
    assign be_bus   = tb_wr_en ? 4'hF  : 'z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        oe_n;
        logic        rd_n;
        logic        wr_n;
        logic [31:0] wd;
        logic        htx_v;
        logic [31:0] htx_d;
        logic        hrx_r;
        logic        e_rxf_n;
        logic        e_txe_n;
        logic        e_txr;
        logic        e_rxv;
        logic [31:0] e_rx;
        logic        e_drv;
        logic        chk_bus;
        logic [31:0] e_bus;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic oe_n, input logic rd_n, input logic wr_n,
                         input logic [31:0] wd, input logic htx_v, input logic [31:0] htx_d,
                         input logic hrx_r);
        rst_i                  = rst;
        bus_if.OE_N_i          = oe_n;
        bus_if.RD_N_i          = rd_n;
        bus_if.WR_N_i          = wr_n;
        tb_wd                  = wd;
        bus_if.H_TX_VALID_i    = htx_v;
        bus_if.H_TX_DATA_i     = htx_d;
        bus_if.H_TX_BE_i       = 4'hF;
        bus_if.H_RX_READY_i    = hrx_r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        idle();
        tick();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            rst oe rd wr wd            htxv htxd          hrxr | rxf txe txr rxv rx            drv chk bus
        vecs[0]  = '{1'b1,1'b1,1'b1,1'b1,32'h0,        1'b0,32'h0,        1'b0, 1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0};
        vecs[1]  = '{1'b1,1'b1,1'b1,1'b1,32'h0,        1'b1,32'hAAAAAAAA, 1'b0, 1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b1,1'b1,1'b1,32'h0,        1'b0,32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0};
        vecs[3]  = '{1'b0,1'b1,1'b1,1'b1,32'h0,        1'b1,32'h11111111, 1'b0, 1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0};
        vecs[4]  = '{1'b0,1'b1,1'b1,1'b1,32'h0,        1'b1,32'h22222222, 1'b0, 1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,32'h0,        1'b1,32'h33333333, 1'b0, 1'b0,1'b0,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h11111111};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,        1'b0,32'h0,        1'b0, 1'b0,1'b0,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h22222222};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,        1'b0,32'h0,        1'b0, 1'b0,1'b0,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h33333333};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,        1'b0,32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,        1'b1,32'h44444444, 1'b0, 1'b0,1'b0,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h44444444};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,32'h0,        1'b0,32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b1,32'h0,        1'b0,32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0};
        vecs[12] = '{1'b0,1'b1,1'b1,1'b0,32'hA5A50001, 1'b0,32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b1,32'hA5A50001, 1'b0,1'b0,32'h0};
        vecs[13] = '{1'b0,1'b1,1'b1,1'b0,32'hA5A50002, 1'b0,32'h0,        1'b1, 1'b1,1'b0,1'b1,1'b1,32'hA5A50002, 1'b0,1'b0,32'h0};
        vecs[14] = '{1'b0,1'b1,1'b1,1'b1,32'h0,        1'b0,32'h0,        1'b1, 1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0};
        vecs[15] = '{1'b0,1'b0,1'b1,1'b0,32'h5A5A0003, 1'b0,32'h0,        1'b0, 1'b1,1'b0,1'b1,1'b1,32'h5A5A0003, 1'b0,1'b0,32'h0};
        vecs[16] = '{1'b0,1'b1,1'b1,1'b1,32'h0,        1'b0,32'h0,        1'b1, 1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0};

        // Table: reset, 3-word host->FPGA burst, ignored RD, up-path push/pop.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].oe_n, vecs[i].rd_n, vecs[i].wr_n, vecs[i].wd,
                  vecs[i].htx_v, vecs[i].htx_d, vecs[i].hrx_r);
            tick();
            chk($sformatf("v%0d_rxf_n", i), 32'(bus_if.RXF_N_o), 32'(vecs[i].e_rxf_n));
            chk($sformatf("v%0d_txe_n", i), 32'(bus_if.TXE_N_o), 32'(vecs[i].e_txe_n));
            chk($sformatf("v%0d_tx_ready", i), 32'(bus_if.H_TX_READY_o), 32'(vecs[i].e_txr));
            chk($sformatf("v%0d_rx_valid", i), 32'(bus_if.H_RX_VALID_o), 32'(vecs[i].e_rxv));
            chk($sformatf("v%0d_bus_drive", i), 32'(dut.bus_drive), 32'(vecs[i].e_drv));
            if (vecs[i].e_rxv) begin
                chk($sformatf("v%0d_rx_data", i), bus_if.H_RX_DATA_o, vecs[i].e_rx);
                chk($sformatf("v%0d_rx_be", i), 32'(bus_if.H_RX_BE_o), 32'hF);
            end
            if (vecs[i].chk_bus) begin
                chk($sformatf("v%0d_bus_data", i), data_bus, vecs[i].e_bus);
                chk($sformatf("v%0d_bus_be", i), 32'(be_bus), 32'hF);
            end
`ifndef FT60X_DEV_PROTOCHK_EN
            chk($sformatf("v%0d_err", i), 32'(err_o), 32'h0);
`endif
        end

        // Fill up FIFO to 16, drop the 17th write, host drains in order.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'(i), 1'b0, 32'h0, 1'b0);
            tick();
            chk($sformatf("fill%0d_txe_n", i), 32'(bus_if.TXE_N_o), 32'(i == 15));
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        tick();
        chk("drop17_txe_n", 32'(bus_if.TXE_N_o), 32'h1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
            #1;
            chk($sformatf("drain%0d_valid", i), 32'(bus_if.H_RX_VALID_o), 32'h1);
            chk($sformatf("drain%0d_data", i), bus_if.H_RX_DATA_o, 32'(i));
            tick();
        end
        idle();
        chk("drain_empty_valid", 32'(bus_if.H_RX_VALID_o), 32'h0);
        chk("drain_empty_txe_n", 32'(bus_if.TXE_N_o), 32'h0);

        // Full up FIFO: host pop frees space while a write is attempted.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(i), 1'b0, 32'h0, 1'b0);
            tick();
        end
        chk("full_txe_n", 32'(bus_if.TXE_N_o), 32'h1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h00000BAD, 1'b0, 32'h0, 1'b1);
        tick();
        chk("freed_txe_n", 32'(bus_if.TXE_N_o), 32'h0);
        chk("freed_head", bus_if.H_RX_DATA_o, 32'h101);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h110, 1'b0, 32'h0, 1'b0);
        tick();
        chk("refull_txe_n", 32'(bus_if.TXE_N_o), 32'h1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
            #1;
            chk($sformatf("refull_drain%0d", i), bus_if.H_RX_DATA_o, 32'h101 + 32'(i));
            tick();
        end
        chk("refull_empty", 32'(bus_if.H_RX_VALID_o), 32'h0);

        // Simultaneous host push and master pop on a 1-word down FIFO, across wrap.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 32'hC0000000, 1'b0);
        tick();
        chk("stream_first_rxf_n", 32'(bus_if.RXF_N_o), 32'h0);
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'hC0000000 + 32'(k + 1), 1'b0);
            #1;
            chk($sformatf("stream%0d_bus", k), data_bus, 32'hC0000000 + 32'(k));
            tick();
            chk($sformatf("stream%0d_rxf_n", k), 32'(bus_if.RXF_N_o), 32'h0);
            chk($sformatf("stream%0d_txr", k), 32'(bus_if.H_TX_READY_o), 32'h1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("stream_last_bus", data_bus, 32'hC0000014);
        tick();
        chk("stream_end_rxf_n", 32'(bus_if.RXF_N_o), 32'h1);

        // Reset asserted mid read burst discards everything.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h77, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 32'hE0 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        chk("burst_bus", data_bus, 32'hE2);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("rst_bus_released", 32'(dut.bus_drive), 32'h0);
        tick();
        chk("rst_rxf_n", 32'(bus_if.RXF_N_o), 32'h1);
        chk("rst_txe_n", 32'(bus_if.TXE_N_o), 32'h1);
        chk("rst_txr", 32'(bus_if.H_TX_READY_o), 32'h0);
        chk("rst_rxv", 32'(bus_if.H_RX_VALID_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_bus_drive", 32'(dut.bus_drive), 32'h0);
        idle();
        tick();
        chk("post_rst_rxf_n", 32'(bus_if.RXF_N_o), 32'h1);
        chk("post_rst_txe_n", 32'(bus_if.TXE_N_o), 32'h0);
        chk("post_rst_txr", 32'(bus_if.H_TX_READY_o), 32'h1);
        chk("post_rst_rxv", 32'(bus_if.H_RX_VALID_o), 32'h0);

`ifdef FT60X_DEV_PROTOCHK_EN
        // OE and WR low together: flag sets, bus not driven, sticky until reset.
        do_reset();
        chk("err_clear", 32'(err_o), 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0, 32'h0, 1'b0);
        #1;
        chk("err_cycle_bus_drive", 32'(dut.bus_drive), 32'h0);
        tick();
        chk("err_set", 32'(err_o), 32'h1);
        idle();
        tick();
        tick();
        tick();
        chk("err_sticky", 32'(err_o), 32'h1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("err_rst_clear", 32'(err_o), 32'h0);
        idle();
        tick();
        chk("err_idle_clear", 32'(err_o), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("err_rd_no_oe", 32'(err_o), 32'h1);
`else
        chk("err_tied_low", 32'(err_o), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ft60x_dev_model.md
FT60X_DEV_MODEL -- requirements
Module: ft60x_dev_model

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of the entry count of each internal FIFO (16 entries per direction).
REQ-002 SHALL have one clock and a synchronous, active-high reset: CLK_i clocks all logic; Rst_i is the synchronous active-high reset.
REQ-003 CLK_i  input  1  sole clock; all registers on its rising edge.
REQ-004 Rst_i  input  1  synchronous active-high reset.
REQ-005 DATA_io  inout  32  FIFO bus data.
REQ-006 BE_io  inout  4  FIFO bus byte enables.
REQ-007 RXF_N_o  output  1  low when the down FIFO (device to FPGA) holds data.
REQ-008 TXE_N_o  output  1  low when the up FIFO (FPGA to device) has space.
REQ-009 OE_N_i  input  1  bus output enable from the FPGA master.
REQ-010 RD_N_i  input  1  read strobe from the FPGA master.
REQ-011 WR_N_i  input  1  write strobe from the FPGA master.
REQ-012 H_TX_DATA_i / H_TX_BE_i / H_TX_VALID_i  input  32/4/1  host word to deliver to the FPGA.
REQ-013 H_TX_READY_o  output  1  down FIFO not full.
REQ-014 H_RX_DATA_o / H_RX_BE_o / H_RX_VALID_o  output  32/4/1  word received from the FPGA (head of the up FIFO).
REQ-015 H_RX_READY_i  input  1  host consumes the head word.
REQ-016 ERR_o  output  1  sticky protocol-error flag.

Function
REQ-017 Down FIFO push SHALL occur on an edge with H_TX_VALID_i=1 and H_TX_READY_o=1; H_TX_READY_o is 1 exactly when occupancy < 2^DEPTH_LOG2.
REQ-018 Down FIFO pop SHALL occur on an edge with OE_N_i=0, RD_N_i=0 and RXF_N_o=0; the next head word is presented on DATA_io/BE_io after that edge.
REQ-019 DATA_io/BE_io SHALL be driven with the down-FIFO head only when OE_N_i=0 and WR_N_i=1; otherwise both SHALL be high-Z.
REQ-020 Up FIFO push SHALL capture DATA_io and BE_io on an edge with WR_N_i=0 and TXE_N_o=0; the up FIFO pops on H_RX_VALID_i... H_RX_VALID_o=1 and H_RX_READY_i=1.
REQ-021 H_RX_VALID_o SHALL be 1 exactly when the up-FIFO occupancy is nonzero.
REQ-022 RXF_N_o SHALL be registered and equal (down occupancy after this edge == 0); TXE_N_o SHALL be registered and equal (up occupancy after this edge == 2^DEPTH_LOG2).
REQ-023 Consequence: the last pop drives RXF_N_o high at that same edge; the master gets no extra word.
REQ-024 A push and a pop on the same FIFO at the same edge SHALL both complete, leaving the occupancy unchanged; this includes the full and empty cases only where a legal push or pop exists.
REQ-025 Pointers SHALL be DEPTH_LOG2 bits wide and wrap modulo 2^DEPTH_LOG2; occupancy SHALL be DEPTH_LOG2+1 bits wide.
REQ-026 A strobe without its qualifying flag SHALL be ignored: RD_N_i=0 while RXF_N_o=1 causes no pop, and WR_N_i=0 while TXE_N_o=1 causes no push.

Reset
REQ-027 While Rst_i=1, both FIFOs SHALL be emptied, RXF_N_o=1, TXE_N_o=1, H_TX_READY_o=0, H_RX_VALID_o=0, ERR_o=0, and the bus SHALL be high-Z.
REQ-028 On the first edge after Rst_i falls, TXE_N_o SHALL go 0 and H_TX_READY_o SHALL go 1.
REQ-029 Assertion of Rst_i mid-burst SHALL discard all stored words at that edge.

Configuration
REQ-030 With FT60X_DEV_PROTOCHK_EN defined, ERR_o SHALL set on any edge with one of the following, and clear only on reset:
- OE_N_i=0 and WR_N_i=0;
- RD_N_i=0 and OE_N_i=1;
- RD_N_i=0 and RXF_N_o=1;
- WR_N_i=0 and TXE_N_o=1.
REQ-031 Without FT60X_DEV_PROTOCHK_EN, ERR_o SHALL be tied 0 and no checker logic is synthesized.

Verification
REQ-032 Host pushes 0x11111111, 0x22222222, 0x33333333 -> RXF_N_o falls the edge after the first push; master OE/RD burst reads exactly those 3 words in order, and RXF_N_o rises at the third pop.
REQ-033 Master writes 16 words 0x0..0xF with BE=0xF and H_RX_READY_i=0 -> TXE_N_o rises at the 16th push; a 17th WR_N_i=0 cycle is dropped; the host then reads 0x0..0xF.
REQ-034 Up FIFO at 16 entries with H_RX_READY_i=1 and WR_N_i=0 for one cycle -> the pop frees space, TXE_N_o goes low the following edge, and no word is lost.
REQ-035 Simultaneous host push and master pop with the down FIFO holding 1 word -> occupancy stays 1, RXF_N_o stays 0, and the data order is preserved across the pointer wrap after 20 cycles.
REQ-036 With FT60X_DEV_PROTOCHK_EN defined, drive OE_N_i=0 and WR_N_i=0 for one cycle -> ERR_o=1 and stays 1 until Rst_i; the bus is not driven during that cycle.
REQ-037 Assert Rst_i during a 5-word read burst -> RXF_N_o=1, the bus is high-Z, and the FIFOs are empty after the edge.
